// File: rtl/lvds_rx_7bit_aligner_if.sv
// Word-level bus between the LVDS receive deserializers, the 7-bit aligner
// and its downstream consumer.
interface lvds_rx_7bit_aligner_if #(
  parameter int unsigned LANES = 4
);
  logic [6:0]         CLK_WORD;
  logic [7*LANES-1:0] DATA_IN;
  logic [7*LANES-1:0] DATA_OUT;
  logic               DATA_VALID;
  logic               LOCK;
  logic [2:0]         OFFSET;
  logic               ALIGN_ERR;

  modport master (
    output CLK_WORD, DATA_IN,
    input  DATA_OUT, DATA_VALID, LOCK, OFFSET, ALIGN_ERR
  );

  modport slave (
    input  CLK_WORD, DATA_IN,
    output DATA_OUT, DATA_VALID, LOCK, OFFSET, ALIGN_ERR
  );
endinterface

// File: rtl/lvds_rx_7bit_aligner.sv
// 7:1 LVDS receive word aligner: searches the clock lane for CLK_PATTERN
// across the 7 bit offsets and applies the found offset to every data lane.
module lvds_rx_7bit_aligner #(
  parameter int unsigned LANES       = 4,
  parameter bit          INV_BITS    = 1'b0,
  parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
  parameter int unsigned MATCH_CNT   = 16,
  parameter int unsigned ERR_LIMIT   = 4
) (
  input logic                   CLK,
  input logic                   RST_N,
  lvds_rx_7bit_aligner_if.slave bus
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0] LP_MATCH_LAST = 8'(MATCH_CNT - 1);
  localparam logic [3:0] LP_ERR_LAST   = 4'(ERR_LIMIT - 1);

  function automatic logic [6:0] f_rev(input logic [6:0] w);
    f_rev = {<<{w}};
  endfunction

  // cat[0] is the oldest received bit; offset s selects cat[s+6:s]
  function automatic logic [6:0] f_window(input logic [13:0] cat, input logic [2:0] s);
    f_window = 7'(cat >> s);
  endfunction

  logic [6:0]         w_clk_in;
  logic [7*LANES-1:0] w_data_in;
  logic [6:0]         w_clk_win;
  logic [7*LANES-1:0] w_data_win;
  logic               w_match;
  logic [2:0]         w_offset_inc;

  logic [6:0]         r_cur_clk;
  logic [6:0]         r_prev_clk;
  logic [7*LANES-1:0] r_cur_data;
  logic [7*LANES-1:0] r_prev_data;
  logic [6:0]         r_clk_al;
  logic [7*LANES-1:0] r_data_out;

  logic [1:0]         r_state;
  logic [1:0]         r_settle;
  logic [2:0]         r_offset;
  logic [7:0]         r_vcnt;
  logic [3:0]         r_ecnt;
  logic               r_lock;
  logic               r_align_err;

  assign w_clk_in  = INV_BITS ? f_rev(bus.CLK_WORD) : bus.CLK_WORD;
  assign w_clk_win = f_window({r_cur_clk, r_prev_clk}, r_offset);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_data_in[7*l +: 7]  = INV_BITS ? f_rev(bus.DATA_IN[7*l +: 7]) : bus.DATA_IN[7*l +: 7];
    assign w_data_win[7*l +: 7] = f_window({r_cur_data[7*l +: 7], r_prev_data[7*l +: 7]}, r_offset);
  end

  assign w_match      = (r_clk_al == CLK_PATTERN);
  assign w_offset_inc = (r_offset == 3'd6) ? 3'd0 : r_offset + 3'd1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cur_clk   <= '0;
      r_prev_clk  <= '0;
      r_cur_data  <= '0;
      r_prev_data <= '0;
      r_clk_al    <= '0;
      r_data_out  <= '0;
    end else begin
      r_cur_clk   <= w_clk_in;
      r_prev_clk  <= r_cur_clk;
      r_cur_data  <= w_data_in;
      r_prev_data <= r_cur_data;
      r_clk_al    <= w_clk_win;
      r_data_out  <= w_data_win;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_HUNT;
      r_settle    <= '0;
      r_offset    <= '0;
      r_vcnt      <= '0;
      r_ecnt      <= '0;
      r_lock      <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          // clk_al only reflects a new offset one edge after it changes
          if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
          end else if (w_match) begin
            r_state  <= ST_VERIFY;
            r_vcnt   <= 8'd1;
            r_settle <= '0;
          end else begin
            r_offset <= w_offset_inc;
            r_settle <= '0;
          end
        end
        ST_VERIFY: begin
          if (w_match) begin
            if (r_vcnt == LP_MATCH_LAST) begin
              r_state <= ST_LOCKED;
              r_lock  <= 1'b1;
              r_vcnt  <= '0;
              r_ecnt  <= '0;
            end else begin
              r_vcnt <= r_vcnt + 8'd1;
            end
          end else begin
            r_state  <= ST_HUNT;
            r_offset <= w_offset_inc;
            r_vcnt   <= '0;
            r_settle <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            r_ecnt <= '0;
          end else if (r_ecnt == LP_ERR_LAST) begin
            r_state     <= ST_HUNT;
            r_lock      <= 1'b0;
            r_align_err <= 1'b1;
            r_offset    <= w_offset_inc;
            r_ecnt      <= '0;
            r_settle    <= '0;
          end else begin
            r_ecnt <= r_ecnt + 4'd1;
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_lock   <= 1'b0;
          r_settle <= '0;
          r_vcnt   <= '0;
          r_ecnt   <= '0;
        end
      endcase
    end
  end

  assign bus.DATA_OUT   = r_data_out;
  assign bus.DATA_VALID = r_lock;
  assign bus.LOCK       = r_lock;
  assign bus.OFFSET     = r_offset;
  assign bus.ALIGN_ERR  = r_align_err;

endmodule

// File: doc/lvds_rx_7bit_aligner.md
# lvds_rx_7bit_aligner

Receive-side word aligner for the 7:1 LVDS link driven by the 7-bit serializer transmitter. It takes unaligned 7-bit parallel words from the receive deserializers: one clock lane plus `LANES` data lanes, all on the same parallel clock. It finds the bit offset at which the clock lane shows the transmitted clock pattern, then applies that offset to every data lane. Aligned words are delivered in the same bit order as the transmitter's `DATA` input, together with a lock indication.

## Interface
- `LANES`, 4: number of data lanes.
- `INV_BITS`, 0: set to 1 when the transmitter uses `INV_BITS=1`. The receiver reverses each input word before alignment.
- `CLK_PATTERN`, 7'b1100011: expected aligned clock-lane word, bit 0 received first.
- `MATCH_CNT`, 16: consecutive pattern matches required to declare lock (2..255).
- `ERR_LIMIT`, 4: consecutive mismatches while locked that drop lock (1..15).

Ports:
- `CLK` in 1: parallel word clock.
- `RST_N` in 1: synchronous, active-low reset.
- `CLK_WORD` in 7: raw deserialized clock-lane word, bit 0 received first.
- `DATA_IN` in 7*LANES: raw data-lane words; lane i is at [7i+6:7i].
- `DATA_OUT` out 7*LANES: aligned data words, registered.
- `DATA_VALID` out 1: `DATA_OUT` is aligned; equals the lock state for the same cycle.
- `LOCK` out 1: aligner is in LOCKED.
- `OFFSET` out 3: current bit offset, 0..6.
- `ALIGN_ERR` out 1: one-cycle pulse when lock is lost.

## Operation
- Input stage: if `INV_BITS`=1, reverse each 7-bit word (bit k goes to bit 6-k). Register the result as `cur`. The previous `cur` is held as `prev`.
- Window: `cat = {cur, prev}` (14 bits; `cat[0]` is the oldest bit). The window at offset s is `cat[s+6:s]`. The window is applied identically to the clock lane and every data lane.
- Output stage: windowed words are registered into `DATA_OUT`. The windowed clock word is registered into an internal `clk_al`.
- `match` = (`clk_al` == `CLK_PATTERN`). Any single rotation of the pattern matches at exactly one offset.
- Offset increment wraps 6 to 0.

State machine (states HUNT, VERIFY, LOCKED):
- HUNT:
  - 2-cycle settle counter after entry or after any offset change; `match` is ignored while settling.
  - On the 3rd cycle: if `match`, go to VERIFY with `vcnt`=1. Otherwise increment `OFFSET` and restart settle.
- VERIFY:
  - On each `match`, increment `vcnt`.
  - When `vcnt` reaches `MATCH_CNT`, go to LOCKED.
  - Any mismatch: go to HUNT, increment `OFFSET`, and clear `vcnt`.
- LOCKED:
  - `ecnt` counts consecutive mismatches and is cleared by any match.
  - When `ecnt` reaches `ERR_LIMIT`: go to HUNT, pulse `ALIGN_ERR` for 1 cycle, increment `OFFSET`.
  - `OFFSET` is never changed while locked.
- `MATCH_CNT`=1 is not supported (minimum is 2).

Reset (`RST_N`=0 at a rising edge), including mid-lock or mid-search:
- state HUNT, settle counter 0, `OFFSET`=0, `vcnt`/`ecnt`=0.
- `cur`, `prev`, `clk_al`, `DATA_OUT` = 0.
- `LOCK`, `DATA_VALID`, `ALIGN_ERR` = 0.
- The first cycle after release is settle cycle 0.

## Timing
- Latency: an input word presented at edge n is in `cur` after edge n. It contributes to `DATA_OUT` after edge n+1 (through the current window) and again after edge n+2 (as `prev`). Fixed 2-cycle pipeline.
- An `OFFSET` change takes effect on `DATA_OUT`/`clk_al` at the next edge. The settle window covers this with 1 spare cycle.
- `LOCK` and `DATA_VALID` rise on the edge that enters LOCKED and fall on the edge that leaves it.
- `ALIGN_ERR` is high for exactly the cycle after that edge.
- `DATA_OUT` updates every cycle regardless of state. Downstream qualifies it with `DATA_VALID`.
- Simultaneous events:
  - A match on the cycle `ecnt` would reach `ERR_LIMIT` clears `ecnt`; lock is held.
  - Reset has priority over every transition.

## Test plan
1. Reset and acquisition, `CLK_PATTERN` arriving at true offset 3 (1100011 stream continuous):
   - Cycle 0 is the first cycle after `RST_N` rises. Offsets 0, 1, 2 fail at cycles 2, 5, 8.
   - Offset 3 matches at cycle 11 (VERIFY, `vcnt`=1).
   - `LOCK`=1 from cycle 27 with `OFFSET`=3.
2. Data integrity after lock:
   - Transmit a lane-0 word sequence of incrementing 7'h00..7'h7F, aligned to the clock lane.
   - After lock, `DATA_OUT[6:0]` reproduces the sequence exactly, 2 cycles after each word is recoverable. Repeat with `INV_BITS`=1 on both ends.
3. Verify abort:
   - Inject one corrupted clock word (7'b0000000) at `vcnt`=8.
   - Required: return to HUNT, `OFFSET` increments to 4, then wraps through 6, 0, 1, 2 and reacquires 3.
   - `LOCK` stays 0 until a full 16 matches.
4. Lock loss:
   - In LOCKED, corrupt 3 consecutive clock words, then send 1 good word, then 3 more bad words. Required: lock held, `ALIGN_ERR` not pulsed.
   - Then send 4 consecutive bad words. Required: `LOCK` falls, `ALIGN_ERR` pulses once, `OFFSET` becomes old+1 mod 7.
5. Offset wrap:
   - Pattern at true offset 0 but hunt started at offset 1 (after loss from offset 0).
   - Required: search 1→6→0, relock at `OFFSET`=0.
6. Reset mid-lock:
   - Assert `RST_N`=0 for 1 cycle while locked at offset 5.
   - Required: the next cycle shows `LOCK`=0, `DATA_OUT`=0, `OFFSET`=0. Reacquisition then follows the scenario 1 timing for offset 5 (`LOCK` at cycle 33).
